// File: rtl/sample_timer.sv
// sample_timer: counts rising edges of the sample-done strobe D_done and
// signals expiry after a programmable number of samples, either once
// (one-shot record-length limit) or repeatedly (periodic frame tick).
//
// Optional build macro: SAMPLE_TIMER_SYNC_EN
//   Defined   - D_done passes through a two-flop synchroniser before edge
//               detection, so it may come from an unrelated clock domain.
//               Tick latency grows by two cycles.
//   Undefined - D_done must already be synchronous to clk.
module sample_timer #(
  parameter int CNT_W = 24,
  parameter int PER_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             D_done,
  input  logic             start,
  input  logic             stop,
  input  logic             mode_i,
  input  logic [CNT_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             done_pulse_o,
  output logic [CNT_W-1:0] elapsed_o,
  output logic [CNT_W-1:0] remaining_o,
  output logic [PER_W-1:0] period_cnt_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [PER_W-1:0] PER_MAX = '1;
  localparam logic [CNT_W-1:0] LEN_MIN = CNT_W'(1);

  // Edge-detect source (raw or synchronised strobe)
  logic d_in;
  logic d_q;
  logic d_q2;
  logic tick;

`ifdef SAMPLE_TIMER_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  // Two-flop synchroniser for a D_done from another clock domain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= D_done;
      sync2_q <= sync1_q;
    end
  end

  assign d_in = sync2_q;
`else
  assign d_in = D_done;
`endif

  // Register the strobe twice so a held-high level yields a single tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_q  <= 1'b0;
      d_q2 <= 1'b0;
    end else begin
      d_q  <= d_in;
      d_q2 <= d_q;
    end
  end

  assign tick = d_q & ~d_q2;

  // Timer state
  logic [1:0]       state_q,      state_d;
  logic [CNT_W-1:0] len_q,        len_d;
  logic             mode_q,       mode_d;
  logic [CNT_W-1:0] elapsed_q,    elapsed_d;
  logic [PER_W-1:0] period_cnt_q, period_cnt_d;
  logic             done_pulse_q, done_pulse_d;

  // One extra bit so the increment never wraps before the compare
  logic [CNT_W:0] elapsed_inc;
  logic           last_tick;

  assign elapsed_inc = {1'b0, elapsed_q} + 1'b1;
  assign last_tick   = (elapsed_inc == {1'b0, len_q});

  // Next-state: start beats stop, and both swallow a same-cycle tick
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    mode_d       = mode_q;
    elapsed_d    = elapsed_q;
    period_cnt_d = period_cnt_q;
    done_pulse_d = 1'b0;

    if (start) begin
      state_d      = ST_RUN;
      len_d        = (len_i == '0) ? LEN_MIN : len_i;
      mode_d       = mode_i;
      elapsed_d    = '0;
      period_cnt_d = '0;
    end else if (stop) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_RUN && tick) begin
      if (last_tick) begin
        done_pulse_d = 1'b1;
        if (mode_q) begin
          elapsed_d = '0;
          if (period_cnt_q != PER_MAX) begin
            period_cnt_d = period_cnt_q + 1'b1;
          end
        end else begin
          elapsed_d = len_q;
          state_d   = ST_HOLD;
        end
      end else begin
        elapsed_d = elapsed_inc[CNT_W-1:0];
      end
    end
  end

  // State registers; reset aborts any run without emitting a pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      mode_q       <= 1'b0;
      elapsed_q    <= '0;
      period_cnt_q <= '0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      mode_q       <= mode_d;
      elapsed_q    <= elapsed_d;
      period_cnt_q <= period_cnt_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  assign busy_o       = (state_q == ST_RUN);
  assign done_o       = (state_q == ST_HOLD);
  assign done_pulse_o = done_pulse_q;
  assign elapsed_o    = elapsed_q;
  assign remaining_o  = len_q - elapsed_q;
  assign period_cnt_o = period_cnt_q;

endmodule

// File: tb/tb_sample_timer.sv
// Testbench for sample_timer: directed scenarios followed by randomized
// start/pulse/stop sequences, all checked against an event-level model.
module tb_sample_timer;

  localparam int CNT_W = 8;
  localparam int PER_W = 3;
`ifdef SAMPLE_TIMER_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  localparam int PMAX = (1 << PER_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             D_done = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             mode_i = 1'b0;
  logic [CNT_W-1:0] len_i = '0;
  logic             busy_o;
  logic             done_o;
  logic             done_pulse_o;
  logic [CNT_W-1:0] elapsed_o;
  logic [CNT_W-1:0] remaining_o;
  logic [PER_W-1:0] period_cnt_o;

  int n_tests = 0;
  int n_fail = 0;
  int n_dp = 0;
  int busy_low = 0;
  bit watch_busy = 1'b0;

  // Event-level reference: one call per D_done pulse, not per clock
  bit m_run = 1'b0;
  bit m_hold = 1'b0;
  bit m_mode = 1'b0;
  int m_len = 0;
  int m_el = 0;
  int m_per = 0;
  int m_dp = 0;

  sample_timer #(.CNT_W(CNT_W), .PER_W(PER_W)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .D_done(D_done),
    .start(start),
    .stop(stop),
    .mode_i(mode_i),
    .len_i(len_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .done_pulse_o(done_pulse_o),
    .elapsed_o(elapsed_o),
    .remaining_o(remaining_o),
    .period_cnt_o(period_cnt_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done_pulse_o === 1'b1) n_dp++;
    if (watch_busy && busy_o !== 1'b1) busy_low++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic m_start(input int len, input bit mode);
    m_run  = 1'b1;
    m_hold = 1'b0;
    m_len  = (len == 0) ? 1 : len;
    m_mode = mode;
    m_el   = 0;
    m_per  = 0;
  endtask

  task automatic m_stop();
    m_run  = 1'b0;
    m_hold = 1'b0;
  endtask

  task automatic m_reset();
    m_run  = 1'b0;
    m_hold = 1'b0;
    m_len  = 0;
    m_mode = 1'b0;
    m_el   = 0;
    m_per  = 0;
  endtask

  task automatic m_pulse();
    if (m_run) begin
      m_el++;
      if (m_el == m_len) begin
        m_dp++;
        if (m_mode) begin
          m_el = 0;
          if (m_per < PMAX) m_per++;
        end else begin
          m_run  = 1'b0;
          m_hold = 1'b1;
        end
      end
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".busy"},      32'(busy_o),       32'(m_run));
    chk({tag, ".done"},      32'(done_o),       32'(m_hold));
    chk({tag, ".elapsed"},   32'(elapsed_o),    32'(m_el));
    chk({tag, ".remaining"}, 32'(remaining_o),  32'(m_len - m_el));
    chk({tag, ".period"},    32'(period_cnt_o), 32'(m_per));
    chk({tag, ".pulses"},    32'(n_dp),         32'(m_dp));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len, input bit mode);
    len_i  = CNT_W'(len);
    mode_i = mode;
    start  = 1'b1;
    step();
    start  = 1'b0;
    len_i  = CNT_W'($urandom);
    mode_i = 1'($urandom);
    m_start(len, mode);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
    m_stop();
  endtask

  task automatic pulse(input int hi, input int lo);
    D_done = 1'b1;
    repeat (hi) step();
    D_done = 1'b0;
    repeat (lo) step();
    m_pulse();
  endtask

  initial begin
    int dp0;
    int lat_p;
    int lat_d;
    int wide;

    // Reset state
    repeat (3) step();
    chk("rst.busy",      32'(busy_o),       0);
    chk("rst.done",      32'(done_o),       0);
    chk("rst.pulse",     32'(done_pulse_o), 0);
    chk("rst.elapsed",   32'(elapsed_o),    0);
    chk("rst.remaining", 32'(remaining_o),  0);
    chk("rst.period",    32'(period_cnt_o), 0);
    reset_n = 1'b1;
    step();

    // Stop and ticks while idle do nothing
    do_stop();
    pulse(2, LAT + 1);
    chk_model("idle");

    // One-shot, length 5
    dp0 = n_dp;
    do_start(5, 1'b0);
    repeat (5) pulse(2, LAT + 1);
    chk("os5.pulses",    32'(n_dp - dp0),  1);
    chk("os5.done",      32'(done_o),      1);
    chk("os5.elapsed",   32'(elapsed_o),   5);
    chk("os5.remaining", 32'(remaining_o), 0);
    chk("os5.busy",      32'(busy_o),      0);
    pulse(2, LAT + 1);
    chk("os5.extra_pulses",  32'(n_dp - dp0), 1);
    chk("os5.extra_elapsed", 32'(elapsed_o),  5);
    chk_model("os5");

    // Periodic, length 3, ten pulses
    dp0 = n_dp;
    do_start(3, 1'b1);
    busy_low = 0;
    watch_busy = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      pulse(2, LAT + 1);
      chk("per3.pulses", 32'(n_dp - dp0), 32'(i / 3));
    end
    watch_busy = 1'b0;
    chk("per3.busy_low", 32'(busy_low),     0);
    chk("per3.period",   32'(period_cnt_o), 3);
    chk("per3.elapsed",  32'(elapsed_o),    1);
    chk_model("per3");

    // Level held high for 20 cycles counts once
    dp0 = n_dp;
    do_start(2, 1'b0);
    D_done = 1'b1;
    repeat (20) step();
    D_done = 1'b0;
    repeat (LAT + 1) step();
    m_pulse();
    chk("held.elapsed", 32'(elapsed_o),   1);
    chk("held.pulses",  32'(n_dp - dp0),  0);
    chk("held.busy",    32'(busy_o),      1);
    chk_model("held");

    // Length 0 behaves as length 1; stop from HOLD clears done only
    do_start(0, 1'b0);
    pulse(2, LAT + 1);
    chk("len0.done",    32'(done_o),    1);
    chk("len0.elapsed", 32'(elapsed_o), 1);
    chk_model("len0");
    do_stop();
    chk("len0.stop_done",    32'(done_o),    0);
    chk("len0.stop_elapsed", 32'(elapsed_o), 1);
    chk_model("len0stop");

    // start + stop + tick in the same cycle
    do_start(8, 1'b0);
    pulse(2, LAT + 1);
    D_done = 1'b1;
    repeat (LAT - 1) step();
    len_i  = CNT_W'(8);
    mode_i = 1'b0;
    start  = 1'b1;
    stop   = 1'b1;
    step();
    start  = 1'b0;
    stop   = 1'b0;
    m_start(8, 1'b0);
    D_done = 1'b0;
    repeat (LAT + 1) step();
    chk("ssT.busy",    32'(busy_o),    1);
    chk("ssT.elapsed", 32'(elapsed_o), 0);
    chk_model("ssT");

    // stop + tick in the same cycle
    repeat (2) pulse(2, LAT + 1);
    chk("sT.pre_elapsed", 32'(elapsed_o), 2);
    D_done = 1'b1;
    repeat (LAT - 1) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    m_stop();
    D_done = 1'b0;
    repeat (LAT + 1) step();
    chk("sT.busy",    32'(busy_o),    0);
    chk("sT.done",    32'(done_o),    0);
    chk("sT.elapsed", 32'(elapsed_o), 2);
    pulse(2, LAT + 1);
    chk_model("sT");

    // Asynchronous reset mid-run
    do_start(8, 1'b0);
    repeat (4) pulse(2, LAT + 1);
    chk("arst.pre_elapsed", 32'(elapsed_o), 4);
    dp0 = n_dp;
    reset_n = 1'b0;
    #1;
    chk("arst.busy",      32'(busy_o),       0);
    chk("arst.done",      32'(done_o),       0);
    chk("arst.pulse",     32'(done_pulse_o), 0);
    chk("arst.elapsed",   32'(elapsed_o),    0);
    chk("arst.remaining", 32'(remaining_o),  0);
    chk("arst.period",    32'(period_cnt_o), 0);
    repeat (3) step();
    reset_n = 1'b1;
    m_reset();
    step();
    repeat (2) pulse(2, LAT + 1);
    chk("arst.after_pulses", 32'(n_dp - dp0), 0);
    chk_model("arst");

    // Expiry latency from the first sampling edge
    do_start(1, 1'b0);
    step();
    D_done = 1'b1;
    lat_p = 0;
    lat_d = 0;
    wide  = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (done_pulse_o === 1'b1) begin
        wide++;
        if (lat_p == 0) lat_p = k;
      end
      if (lat_d == 0 && done_o === 1'b1) lat_d = k;
    end
    D_done = 1'b0;
    repeat (LAT + 1) step();
    m_pulse();
    chk("lat.pulse", 32'(lat_p), 32'(LAT));
    chk("lat.done",  32'(lat_d), 32'(LAT));
    chk("lat.width", 32'(wide),  1);
    chk_model("lat");

    // Period counter saturation, then restart clears it
    do_start(1, 1'b1);
    repeat (10) pulse(2, LAT + 1);
    chk("sat.period", 32'(period_cnt_o), 32'(PMAX));
    chk_model("sat");
    do_start(4, 1'b1);
    chk_model("restart");

    // Randomized rounds
    for (int r = 0; r < 8; r++) begin
      int np;
      do_start(int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
      np = int'($urandom_range(0, 12));
      for (int p = 0; p < np; p++) begin
        pulse(int'($urandom_range(2, 3)), LAT + 1 + int'($urandom_range(0, 2)));
        if ($urandom_range(0, 9) == 0) do_stop();
      end
      chk_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
